// File: rtl/core_hazard_unit.sv
// Hazard controller for the 5-stage Selen core: stage enables/kills, PC redirect, operand bypass.
// Define HAZ_PERF_CNT_EN to add saturating load-use / redirect / mem-stall event counters.
module core_hazard_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LU_STALL = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] dec_rs_in,
  input  logic [NUM_SRC-1:0]        dec_rs_use_in,
  input  logic [NUM_SRC*REG_AW-1:0] exe_rs_in,
  input  logic [REG_AW-1:0]         exe_rd_in,
  input  logic                      exe_we_in,
  input  logic                      exe_is_load_in,
  input  logic                      exe_redirect_in,
  input  logic [REG_AW-1:0]         mem_rs2_in,
  input  logic [REG_AW-1:0]         mem_rd_in,
  input  logic                      mem_we_in,
  input  logic [REG_AW-1:0]         wb_rd_in,
  input  logic                      wb_we_in,
  input  logic                      if_stall_in,
  input  logic                      mem_stall_in,
  output logic [3:0]                haz_enb_out,
  output logic [3:0]                haz_kill_out,
  output logic                      haz_pc_sel_out,
  output logic [2*NUM_SRC-1:0]      haz_fwd_exe_out,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]               haz_lu_cnt_out,
  output logic [31:0]               haz_redir_cnt_out,
  output logic [31:0]               haz_mstall_cnt_out,
`endif
  output logic                      haz_fwd_mem_out
);

  localparam logic [1:0] StRun  = 2'd0;
  localparam logic [1:0] StLu   = 2'd1;
  localparam logic [1:0] StPend = 2'd2;

  localparam logic [2:0] LuCntInit = 3'(LU_STALL - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] lu_cnt_q, lu_cnt_d;
  logic       pend_redir_q, pend_redir_d;
  logic       lu_hit;

  // Load in EXE whose destination is read by the instruction sitting in DEC.
  always_comb begin
    lu_hit = 1'b0;
    if (exe_is_load_in && exe_we_in && (exe_rd_in != '0)) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (dec_rs_use_in[i] && (dec_rs_in[i*REG_AW +: REG_AW] == exe_rd_in)) begin
          lu_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    haz_fwd_exe_out = '0;
    haz_fwd_mem_out = 1'b0;
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (exe_rs_in[i*REG_AW +: REG_AW] != '0) begin
          // MEM holds the younger result, so it takes precedence over WB.
          if (mem_we_in && (mem_rd_in == exe_rs_in[i*REG_AW +: REG_AW])) begin
            haz_fwd_exe_out[2*i +: 2] = 2'b01;
          end else if (wb_we_in && (wb_rd_in == exe_rs_in[i*REG_AW +: REG_AW])) begin
            haz_fwd_exe_out[2*i +: 2] = 2'b10;
          end
        end
      end
      haz_fwd_mem_out = wb_we_in && (wb_rd_in == mem_rs2_in) && (mem_rs2_in != '0);
    end
  end

  always_comb begin
    haz_enb_out    = 4'b1111;
    haz_kill_out   = 4'b0000;
    haz_pc_sel_out = 1'b0;
    state_d        = state_q;
    lu_cnt_d       = lu_cnt_q;
    pend_redir_d   = pend_redir_q;

    if (rst) begin
      haz_enb_out  = 4'b0000;
      haz_kill_out = 4'b1111;
    end else if (mem_stall_in) begin
      haz_enb_out = 4'b0000;
      // A redirect resolved under a D-cache miss is remembered and applied on release.
      if ((state_q == StRun) && exe_redirect_in) begin
        pend_redir_d = 1'b1;
        state_d      = StPend;
      end
    end else if (pend_redir_q || exe_redirect_in) begin
      haz_pc_sel_out    = 1'b1;
      haz_kill_out[1:0] = 2'b11;
      pend_redir_d      = 1'b0;
      lu_cnt_d          = '0;
      state_d           = StRun;
    end else if ((state_q == StLu) || lu_hit) begin
      haz_enb_out[0]  = 1'b0;
      haz_kill_out[1] = 1'b1;
      if (state_q == StLu) begin
        lu_cnt_d = lu_cnt_q - 3'd1;
        if (lu_cnt_q <= 3'd1) begin
          state_d = StRun;
        end
      end else if (LU_STALL > 1) begin
        lu_cnt_d = LuCntInit;
        state_d  = StLu;
      end
    end else if (if_stall_in) begin
      haz_kill_out[0] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      lu_cnt_q     <= '0;
      pend_redir_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lu_cnt_q     <= lu_cnt_d;
      pend_redir_q <= pend_redir_d;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_redir_q, perf_mstall_q;
  logic        lu_event;

  // kill[1] without a redirect is exactly a load-use bubble cycle.
  assign lu_event = haz_kill_out[1] && !haz_pc_sel_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_lu_q     <= '0;
      perf_redir_q  <= '0;
      perf_mstall_q <= '0;
    end else begin
      if (lu_event && (perf_lu_q != 32'hFFFF_FFFF)) begin
        perf_lu_q <= perf_lu_q + 32'd1;
      end
      if (haz_pc_sel_out && (perf_redir_q != 32'hFFFF_FFFF)) begin
        perf_redir_q <= perf_redir_q + 32'd1;
      end
      if (mem_stall_in && (perf_mstall_q != 32'hFFFF_FFFF)) begin
        perf_mstall_q <= perf_mstall_q + 32'd1;
      end
    end
  end

  assign haz_lu_cnt_out     = perf_lu_q;
  assign haz_redir_cnt_out  = perf_redir_q;
  assign haz_mstall_cnt_out = perf_mstall_q;
`endif

endmodule
